// File: rtl/riscv_dmem_slave_if.sv
`default_nettype none
// ============================================================================
// riscv_dmem_slave_if
// Core data-memory bus: byte-enabled load/store request, registered response.
// Revision: 1.0
// ============================================================================
interface riscv_dmem_slave_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        access_fault;
  logic        timer_irq;

  modport master (
    output dmem_addr, dmem_wdata, dmem_we, dmem_be,
    input  dmem_rdata, access_fault, timer_irq
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_we, dmem_be,
    output dmem_rdata, access_fault, timer_irq
  );
endinterface
`default_nettype wire

// File: rtl/riscv_dmem_slave.sv
`default_nettype none
// ============================================================================
// riscv_dmem_slave
// Data RAM plus mtime/mtimecmp timer window, fixed one-cycle read latency.
// Revision: 1.0
// ============================================================================
module riscv_dmem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input logic               clk,
  input logic               rst,
  riscv_dmem_slave_if.slave dmem
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic          irq_q, irq_d;

  logic [32:0]   w_ram_off;
  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic          w_valid;
  logic          w_store;
  logic [AW-1:0] w_word_idx;
  logic [1:0]    w_reg_sel;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int n = 0; n < 4; n++) begin
      r[8*n +: 8] = be[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
    end
    return r;
  endfunction

  // Below-base addresses wrap into bit 32, so one unsigned compare covers both bounds.
  assign w_ram_off  = {1'b0, dmem.dmem_addr} - {1'b0, RAM_BASE};
  assign w_ram_hit  = (w_ram_off < RAM_BYTES);
  assign w_mmio_hit = !w_ram_hit && (dmem.dmem_addr[31:4] == MMIO_BASE[31:4]);
  assign w_word_idx = dmem.dmem_addr[AW+1:2];
  assign w_reg_sel  = dmem.dmem_addr[3:2];
  assign w_valid    = |dmem.dmem_be;
  assign w_store    = dmem.dmem_we && w_valid;

  // RAM holds its contents through reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_store && w_ram_hit) begin
      for (int n = 0; n < 4; n++) begin
        if (dmem.dmem_be[n]) begin
          mem_q[w_word_idx][8*n +: 8] <= dmem.dmem_wdata[8*n +: 8];
        end
      end
    end
  end

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    rdata_d    = '0;

    if (w_ram_hit) begin
      rdata_d = mem_q[w_word_idx];
    end else if (w_mmio_hit) begin
      case (w_reg_sel)
        2'd0:    rdata_d = mtime_q[31:0];
        2'd1:    rdata_d = mtime_q[63:32];
        2'd2:    rdata_d = mtimecmp_q[31:0];
        default: rdata_d = mtimecmp_q[63:32];
      endcase
    end

    if (w_store && w_mmio_hit) begin
      case (w_reg_sel)
        2'd0: mtime_d = {mtime_q[63:32],
                         merge_bytes(mtime_q[31:0], dmem.dmem_wdata, dmem.dmem_be)};
        2'd1: mtime_d = {merge_bytes(mtime_q[63:32], dmem.dmem_wdata, dmem.dmem_be),
                         mtime_q[31:0]};
        2'd2: mtimecmp_d = {mtimecmp_q[63:32],
                            merge_bytes(mtimecmp_q[31:0], dmem.dmem_wdata, dmem.dmem_be)};
        default: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], dmem.dmem_wdata, dmem.dmem_be),
                               mtimecmp_q[31:0]};
      endcase
    end

    fault_d = w_valid && !w_ram_hit && !w_mmio_hit;
    irq_d   = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
      irq_q      <= irq_d;
    end
  end

  assign dmem.dmem_rdata   = rdata_q;
  assign dmem.access_fault = fault_q;
  assign dmem.timer_irq    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_slave.sv
`default_nettype none
// ============================================================================
// tb_riscv_dmem_slave
// Directed bench for the data-memory responder: RAM, byte lanes, timer, faults.
// Revision: 1.0
// ============================================================================
module tb_riscv_dmem_slave;
  localparam logic [31:0] MMIO = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  int          vec  = 0;
  int          errs = 0;
  logic [63:0] exp_mt;

  riscv_dmem_slave_if bus();

  riscv_dmem_slave dut (
    .clk  (clk),
    .rst  (rst),
    .dmem (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    exp_mt = exp_mt + 64'd1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic [3:0] be);
    bus.dmem_addr  = a;
    bus.dmem_wdata = d;
    bus.dmem_we    = we;
    bus.dmem_be    = be;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(a, d, 1'b1, be);
    cyc();
  endtask

  task automatic ld(input logic [31:0] a);
    drive(a, 32'h0, 1'b0, 4'hF);
    cyc();
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0, 4'h0);
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    vec++; if (bus.dmem_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h want 00000000", bus.dmem_rdata); end
    vec++; if (bus.access_fault !== 1'b0) begin errs++; $display("FAIL reset_fault: got %b want 0", bus.access_fault); end
    vec++; if (bus.timer_irq !== 1'b0) begin errs++; $display("FAIL reset_irq: got %b want 0", bus.timer_irq); end
    rst    = 1'b0;
    exp_mt = 64'd0;
  endtask

  task automatic test_timer();
    repeat (10) idle();
    ld(MMIO);
    vec++; if (bus.dmem_rdata !== 32'd10) begin errs++; $display("FAIL mtime_after_10: got %h want 0000000a", bus.dmem_rdata); end
    st(MMIO + 32'd12, 32'h0, 4'hF);
    vec++; if (bus.timer_irq !== 1'b0) begin errs++; $display("FAIL irq_cmp_hi0: got %b want 0", bus.timer_irq); end
    st(MMIO + 32'd8, 32'd20, 4'hF);
    vec++; if (bus.timer_irq !== 1'b0) begin errs++; $display("FAIL irq_cmp_lo20: got %b want 0", bus.timer_irq); end
    for (int i = 0; i < 10; i++) begin
      idle();
      vec++;
      if (bus.timer_irq !== (exp_mt >= 64'd20)) begin
        errs++;
        $display("FAIL irq_rise mtime=%0d: got %b want %b", exp_mt, bus.timer_irq, exp_mt >= 64'd20);
      end
    end
    st(MMIO + 32'd4, 32'h0, 4'hF);
    st(MMIO, 32'hFFFF_FFFF, 4'hF);
    ld(MMIO);
    vec++; if (bus.dmem_rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mtime_lo_written: got %h want ffffffff", bus.dmem_rdata); end
    ld(MMIO);
    vec++; if (bus.dmem_rdata !== 32'h0) begin errs++; $display("FAIL mtime_lo_wrap: got %h want 00000000", bus.dmem_rdata); end
    ld(MMIO + 32'd4);
    vec++; if (bus.dmem_rdata !== 32'h1) begin errs++; $display("FAIL mtime_hi_carry: got %h want 00000001", bus.dmem_rdata); end
    vec++; if (bus.timer_irq !== 1'b1) begin errs++; $display("FAIL irq_high_after_carry: got %b want 1", bus.timer_irq); end
    st(MMIO + 32'd12, 32'hFFFF_FFFF, 4'hF);
    vec++; if (bus.timer_irq !== 1'b0) begin errs++; $display("FAIL irq_deassert: got %b want 0", bus.timer_irq); end
  endtask

  task automatic test_ram_word();
    st(32'h10, 32'hDEAD_BEEF, 4'hF);
    ld(32'h10);
    vec++; if (bus.dmem_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ram_word: got %h want deadbeef", bus.dmem_rdata); end
  endtask

  task automatic test_lanes();
    st(32'h20, 32'h1122_3344, 4'hF);
    st(32'h20, 32'hAABB_CCDD, 4'b0100);
    ld(32'h20);
    vec++; if (bus.dmem_rdata !== 32'h11BB_3344) begin errs++; $display("FAIL lane_byte2: got %h want 11bb3344", bus.dmem_rdata); end
    st(32'h20, 32'hAABB_CCDD, 4'b0011);
    drive(32'h20, 32'h0, 1'b0, 4'b0001);
    cyc();
    vec++; if (bus.dmem_rdata !== 32'h11BB_CCDD) begin errs++; $display("FAIL lane_half0: got %h want 11bbccdd", bus.dmem_rdata); end
  endtask

  task automatic test_rdw();
    st(32'h30, 32'h1, 4'hF);
    st(32'h30, 32'h2, 4'hF);
    vec++; if (bus.dmem_rdata !== 32'h1) begin errs++; $display("FAIL rdw_old: got %h want 00000001", bus.dmem_rdata); end
    ld(32'h30);
    vec++; if (bus.dmem_rdata !== 32'h2) begin errs++; $display("FAIL rdw_new: got %h want 00000002", bus.dmem_rdata); end
  endtask

  task automatic test_back_to_back();
    st(32'h40, 32'hA5A5_0001, 4'hF);
    st(32'h44, 32'h5A5A_0002, 4'hF);
    st(32'hFFC, 32'hCAFE_F00D, 4'hF);
    ld(32'h40);
    vec++; if (bus.dmem_rdata !== 32'hA5A5_0001) begin errs++; $display("FAIL b2b_0x40: got %h want a5a50001", bus.dmem_rdata); end
    ld(32'h44);
    vec++; if (bus.dmem_rdata !== 32'h5A5A_0002) begin errs++; $display("FAIL b2b_0x44: got %h want 5a5a0002", bus.dmem_rdata); end
    ld(32'hFFC);
    vec++; if (bus.dmem_rdata !== 32'hCAFE_F00D) begin errs++; $display("FAIL ram_last_word: got %h want cafef00d", bus.dmem_rdata); end
    vec++; if (bus.access_fault !== 1'b0) begin errs++; $display("FAIL ram_last_nofault: got %b want 0", bus.access_fault); end
  endtask

  task automatic test_fault();
    st(32'h0, 32'h1234_5678, 4'hF);
    st(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
    vec++; if (bus.access_fault !== 1'b1) begin errs++; $display("FAIL fault_pulse: got %b want 1", bus.access_fault); end
    vec++; if (bus.dmem_rdata !== 32'h0) begin errs++; $display("FAIL fault_rdata: got %h want 00000000", bus.dmem_rdata); end
    idle();
    vec++; if (bus.access_fault !== 1'b0) begin errs++; $display("FAIL fault_one_cycle: got %b want 0", bus.access_fault); end
    drive(32'h2000_0000, 32'hFFFF_FFFF, 1'b1, 4'h0);
    cyc();
    vec++; if (bus.access_fault !== 1'b0) begin errs++; $display("FAIL fault_be0: got %b want 0", bus.access_fault); end
    ld(32'h0);
    vec++; if (bus.dmem_rdata !== 32'h1234_5678) begin errs++; $display("FAIL fault_ram_intact: got %h want 12345678", bus.dmem_rdata); end
    st(32'h1000, 32'h0, 4'hF);
    vec++; if (bus.access_fault !== 1'b1) begin errs++; $display("FAIL fault_ram_end: got %b want 1", bus.access_fault); end
    st(MMIO + 32'd16, 32'h0, 4'h1);
    vec++; if (bus.access_fault !== 1'b1) begin errs++; $display("FAIL fault_consecutive: got %b want 1", bus.access_fault); end
    vec++; if (bus.dmem_rdata !== 32'h0) begin errs++; $display("FAIL fault_mmio_end_rdata: got %h want 00000000", bus.dmem_rdata); end
    idle();
    vec++; if (bus.access_fault !== 1'b0) begin errs++; $display("FAIL fault_clear: got %b want 0", bus.access_fault); end
  endtask

  task automatic test_reset_mid();
    st(MMIO + 32'd12, 32'h0, 4'hF);
    st(MMIO + 32'd4, 32'h0, 4'hF);
    st(MMIO, 32'd499, 4'hF);
    ld(32'h10);
    vec++; if (bus.dmem_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL pre_reset_rdata: got %h want deadbeef", bus.dmem_rdata); end
    vec++; if (bus.timer_irq !== 1'b1) begin errs++; $display("FAIL pre_reset_irq: got %b want 1", bus.timer_irq); end
    drive(MMIO, 32'h0, 1'b0, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    vec++; if (bus.dmem_rdata !== 32'h0) begin errs++; $display("FAIL async_rst_rdata: got %h want 00000000", bus.dmem_rdata); end
    vec++; if (bus.timer_irq !== 1'b0) begin errs++; $display("FAIL async_rst_irq: got %b want 0", bus.timer_irq); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(MMIO, 32'h0, 1'b0, 4'h0);
    cyc();
    vec++; if (bus.dmem_rdata !== 32'h0) begin errs++; $display("FAIL rst_mtime: got %h want 00000000", bus.dmem_rdata); end
    ld(MMIO + 32'd12);
    vec++; if (bus.dmem_rdata !== 32'hFFFF_FFFF) begin errs++; $display("FAIL rst_mtimecmp_hi: got %h want ffffffff", bus.dmem_rdata); end
    ld(32'h10);
    vec++; if (bus.dmem_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rst_ram_kept_10: got %h want deadbeef", bus.dmem_rdata); end
    ld(32'h20);
    vec++; if (bus.dmem_rdata !== 32'h11BB_CCDD) begin errs++; $display("FAIL rst_ram_kept_20: got %h want 11bbccdd", bus.dmem_rdata); end
  endtask

  initial begin
    exp_mt = 64'd0;
    test_reset();
    test_timer();
    test_ram_word();
    test_lanes();
    test_rdw();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
